// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register map, arbiter FSM states, address check.
package gpio_pkg;

  localparam int unsigned REG_ADR_W = 6;

  localparam logic [REG_ADR_W-1:0] RGPIO_IN    = 6'h00;
  localparam logic [REG_ADR_W-1:0] RGPIO_OUT   = 6'h04;
  localparam logic [REG_ADR_W-1:0] RGPIO_OE    = 6'h08;
  localparam logic [REG_ADR_W-1:0] RGPIO_INTE  = 6'h0C;
  localparam logic [REG_ADR_W-1:0] RGPIO_PTRIG = 6'h10;
  localparam logic [REG_ADR_W-1:0] RGPIO_AUX   = 6'h14;
  localparam logic [REG_ADR_W-1:0] RGPIO_CTRL  = 6'h18;
  localparam logic [REG_ADR_W-1:0] RGPIO_INTS  = 6'h1C;
  localparam logic [REG_ADR_W-1:0] RGPIO_ECLK  = 6'h20;
  localparam logic [REG_ADR_W-1:0] RGPIO_NEC   = 6'h24;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  // True for a word-aligned offset inside the register map; callers must also
  // confirm that all address bits above REG_ADR_W are zero.
  function automatic logic reg_adr_valid(input logic [REG_ADR_W-1:0] adr);
    return (adr[1:0] == 2'b00) && (adr <= RGPIO_NEC);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       any_req
);

  // On a tie the loser of the previous grant wins; otherwise the sole requester.
  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = ~last_gnt;
    end else begin
      gnt = req[1];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Shares the single GPIO register port between two requesters, one access at a time.
module gpio_reg_arbiter
  import gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wdat,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdat,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wdat,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdat,
  output logic [ADDR_W-1:0] gpio_adr,
  output logic              gpio_we,
  output logic [DATA_W-1:0] gpio_dat_i,
  input  logic [DATA_W-1:0] gpio_dat_o,
  output logic              busy
);

  arb_state_t state_q, state_d;

  logic last_gnt_q, last_gnt_d;
  logic gnt_q, gnt_d;
  logic we_q, we_d;
  logic err_q, err_d;

  logic              arb_gnt;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_wdat;
  logic              sel_err;

  logic              gpio_we_d;
  logic [ADDR_W-1:0] gpio_adr_d;
  logic [DATA_W-1:0] gpio_dat_i_d;
  logic              m0_ack_d, m1_ack_d;
  logic              m0_err_d, m1_err_d;
  logic [DATA_W-1:0] m0_rdat_d, m1_rdat_d;
  logic              busy_d;

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .any_req  (any_req)
  );

  // Request fields of whichever requester the picker selects.
  always_comb begin
    sel_we   = arb_gnt ? m1_we   : m0_we;
    sel_adr  = arb_gnt ? m1_adr  : m0_adr;
    sel_wdat = arb_gnt ? m1_wdat : m0_wdat;
  end

  // Reject unmapped/misaligned addresses and writes to the read-only input register.
  always_comb begin
    sel_err = 1'b0;
    if (((sel_adr >> REG_ADR_W) != '0) || !reg_adr_valid(sel_adr[REG_ADR_W-1:0])) begin
      sel_err = 1'b1;
    end
    if (sel_we && (sel_adr == '0)) begin
      sel_err = 1'b1;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    err_d        = err_q;
    gpio_we_d    = 1'b0;
    gpio_adr_d   = gpio_adr;
    gpio_dat_i_d = gpio_dat_i;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = m0_err;
    m1_err_d     = m1_err;
    m0_rdat_d    = m0_rdat;
    m1_rdat_d    = m1_rdat;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ACCESS;
          gnt_d        = arb_gnt;
          last_gnt_d   = arb_gnt;
          we_d         = sel_we;
          err_d        = sel_err;
          gpio_adr_d   = sel_adr;
          gpio_dat_i_d = sel_wdat;
          gpio_we_d    = sel_we & ~sel_err;
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
        if (gnt_q == 1'b0) begin
          m0_ack_d = 1'b1;
          m0_err_d = err_q;
          if (err_q) begin
            m0_rdat_d = '0;
          end else if (!we_q) begin
            m0_rdat_d = gpio_dat_o;
          end
        end else begin
          m1_ack_d = 1'b1;
          m1_err_d = err_q;
          if (err_q) begin
            m1_rdat_d = '0;
          end else if (!we_q) begin
            m1_rdat_d = gpio_dat_o;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latched request and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_adr   <= '0;
      gpio_dat_i <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdat    <= '0;
      m1_rdat    <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      gpio_we    <= gpio_we_d;
      gpio_adr   <= gpio_adr_d;
      gpio_dat_i <= gpio_dat_i_d;
      m0_ack     <= m0_ack_d;
      m1_ack     <= m1_ack_d;
      m0_err     <= m0_err_d;
      m1_err     <= m1_err_d;
      m0_rdat    <= m0_rdat_d;
      m1_rdat    <= m1_rdat_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed self-checking bench for gpio_reg_arbiter with a small registered GPIO register file model.
module tb_gpio_reg_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [31:0] gpio_adr, gpio_dat_i;
  logic [31:0] gpio_dat_o = 32'h0;
  logic        gpio_we;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file stand-in: IN holds a fixed pattern, others reset to zero.
  logic [31:0] regs [10] = '{32'hCAFE_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  gpio_reg_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_adr     (m0_adr),
    .m0_wdat    (m0_wdat),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m0_rdat    (m0_rdat),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_adr     (m1_adr),
    .m1_wdat    (m1_wdat),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m1_rdat    (m1_rdat),
    .gpio_adr   (gpio_adr),
    .gpio_we    (gpio_we),
    .gpio_dat_i (gpio_dat_i),
    .gpio_dat_o (gpio_dat_o),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Registered read port and write strobe of the modelled register file.
  always @(posedge sys_clk) begin
    if (gpio_we && gpio_adr < 32'h28) regs[gpio_adr[5:2]] <= gpio_dat_i;
    gpio_dat_o <= (gpio_adr < 32'h28) ? regs[gpio_adr[5:2]] : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input int n, input logic req, input logic we,
                       input logic [31:0] adr, input logic [31:0] wdat);
    if (n == 0) begin
      m0_req = req; m0_we = we; m0_adr = adr; m0_wdat = wdat;
    end else begin
      m1_req = req; m1_we = we; m1_adr = adr; m1_wdat = wdat;
    end
  endtask

  // One access from requester n; lat is -1 if no ack within the budget.
  task automatic access(input int n, input logic we, input logic [31:0] adr,
                        input logic [31:0] wdat, output int lat, output logic err,
                        output logic [31:0] rdat, output int we_cnt,
                        output logic [31:0] we_adr, output logic [31:0] we_dat);
    lat = -1; err = 1'b0; rdat = 32'h0; we_cnt = 0; we_adr = 32'h0; we_dat = 32'h0;
    drive(n, 1'b1, we, adr, wdat);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (gpio_we) begin
        we_cnt++; we_adr = gpio_adr; we_dat = gpio_dat_i;
      end
      if ((n == 0 && m0_ack) || (n == 1 && m1_ack)) begin
        lat  = c;
        err  = (n == 0) ? m0_err : m1_err;
        rdat = (n == 0) ? m0_rdat : m1_rdat;
        break;
      end
    end
    drive(n, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    sys_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err, gpio_we, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {m0_ack, m0_err, m1_ack, m1_err, gpio_we, busy}); end
    n_checks++; if (m0_rdat !== 32'h0) begin n_fail++; $display("FAIL reset_m0_rdat got %h exp 0", m0_rdat); end
    n_checks++; if (m1_rdat !== 32'h0) begin n_fail++; $display("FAIL reset_m1_rdat got %h exp 0", m1_rdat); end
    v = gpio_adr | gpio_dat_i;
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_bus got adr %h dat %h exp 0", gpio_adr, gpio_dat_i); end
    sys_rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_tie();
    int ack_t [3];
    int ack_n [3];
    int k = 0;
    int we_cnt = 0;
    drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h14, 32'hA5);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (gpio_we) we_cnt++;
      if (c == 1) begin
        n_checks++; if (gpio_adr !== 32'h08 || gpio_we !== 1'b0) begin n_fail++; $display("FAIL tie_first_access got adr %h we %b exp 08 0", gpio_adr, gpio_we); end
      end
      if (c == 3) begin
        n_checks++; if (m0_rdat !== 32'h0 || m0_err !== 1'b0) begin n_fail++; $display("FAIL tie_m0_read got rdat %h err %b exp 0 0", m0_rdat, m0_err); end
      end
      if (c == 5) begin
        n_checks++; if (gpio_we !== 1'b1 || gpio_adr !== 32'h14 || gpio_dat_i !== 32'hA5) begin n_fail++; $display("FAIL tie_m1_write got we %b adr %h dat %h exp 1 14 a5", gpio_we, gpio_adr, gpio_dat_i); end
      end
      if (m0_ack && k < 3) begin ack_t[k] = c; ack_n[k] = 0; k++; end
      if (m1_ack && k < 3) begin ack_t[k] = c; ack_n[k] = 1; k++; end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL tie_ack_count got %0d exp 3", k); end
    if (k == 3) begin
      n_checks++; if (ack_t[0] !== 3 || ack_n[0] !== 0) begin n_fail++; $display("FAIL tie_grant0 got t%0d m%0d exp t3 m0", ack_t[0], ack_n[0]); end
      n_checks++; if (ack_t[1] !== 7 || ack_n[1] !== 1) begin n_fail++; $display("FAIL tie_grant1 got t%0d m%0d exp t7 m1", ack_t[1], ack_n[1]); end
      n_checks++; if (ack_t[2] !== 11 || ack_n[2] !== 0) begin n_fail++; $display("FAIL tie_grant2 got t%0d m%0d exp t11 m0", ack_t[2], ack_n[2]); end
    end
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL tie_we_cycles got %0d exp 1", we_cnt); end
    tick();
    n_checks++; if (busy !== 1'b0 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL tie_end_idle got busy %b ack %b exp 0 0", busy, m0_ack); end
  endtask

  task automatic test_write_read();
    int lat, we_cnt;
    logic err;
    logic [31:0] rdat, we_adr, we_dat;
    access(0, 1'b1, 32'h04, 32'h0000_00FF, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d exp 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b exp 0", err); end
    n_checks++; if (we_cnt !== 1 || we_adr !== 32'h04 || we_dat !== 32'hFF) begin n_fail++; $display("FAIL wr_strobe got cnt %0d adr %h dat %h exp 1 04 ff", we_cnt, we_adr, we_dat); end
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse got %b exp 0", m0_ack); end
    access(0, 1'b0, 32'h04, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rdat !== 32'hFF) begin n_fail++; $display("FAIL rd_back got lat %0d err %b rdat %h exp 3 0 ff", lat, err, rdat); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rd_no_strobe got %0d exp 0", we_cnt); end
    access(0, 1'b1, 32'h10, 32'h55, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (rdat !== 32'hFF || err !== 1'b0) begin n_fail++; $display("FAIL wr_rdat_hold got rdat %h err %b exp ff 0", rdat, err); end
  endtask

  task automatic test_errors();
    int lat, we_cnt;
    logic err;
    logic [31:0] rdat, we_adr, we_dat;
    access(1, 1'b0, 32'h00, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rdat !== 32'hCAFE_0000) begin n_fail++; $display("FAIL err_read_in got lat %0d err %b rdat %h exp 3 0 cafe0000", lat, err, rdat); end
    access(1, 1'b1, 32'h00, 32'h1111, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b1 || rdat !== 32'h0) begin n_fail++; $display("FAIL err_write_in got lat %0d err %b rdat %h exp 3 1 0", lat, err, rdat); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL err_write_in_strobe got %0d exp 0", we_cnt); end
    access(1, 1'b0, 32'h00, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (rdat !== 32'hCAFE_0000) begin n_fail++; $display("FAIL err_in_kept got %h exp cafe0000", rdat); end
    access(1, 1'b0, 32'h30, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b1 || rdat !== 32'h0 || we_cnt !== 0) begin n_fail++; $display("FAIL err_read_30 got lat %0d err %b rdat %h we %0d exp 3 1 0 0", lat, err, rdat, we_cnt); end
    access(1, 1'b0, 32'h06, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_misaligned got %b exp 1", err); end
    access(1, 1'b1, 32'h28, 32'h9, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (err !== 1'b1 || we_cnt !== 0) begin n_fail++; $display("FAIL err_write_28 got err %b we %0d exp 1 0", err, we_cnt); end
    access(1, 1'b1, 32'h1_0004, 32'h9, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (err !== 1'b1 || we_cnt !== 0) begin n_fail++; $display("FAIL err_high_bits got err %b we %0d exp 1 0", err, we_cnt); end
    access(1, 1'b1, 32'h24, 32'h7, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (err !== 1'b0 || we_cnt !== 1) begin n_fail++; $display("FAIL nec_write got err %b we %0d exp 0 1", err, we_cnt); end
    access(1, 1'b0, 32'h24, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (err !== 1'b0 || rdat !== 32'h7) begin n_fail++; $display("FAIL nec_read got err %b rdat %h exp 0 7", err, rdat); end
  endtask

  task automatic test_no_stale();
    int lat, we_cnt;
    logic err;
    logic [31:0] rdat, we_adr, we_dat;
    access(0, 1'b1, 32'h04, 32'h1234, lat, err, rdat, we_cnt, we_adr, we_dat);
    access(0, 1'b1, 32'h08, 32'hFFFF, lat, err, rdat, we_cnt, we_adr, we_dat);
    access(1, 1'b0, 32'h04, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rdat !== 32'h1234) begin n_fail++; $display("FAIL stale_out got lat %0d err %b rdat %h exp 3 0 1234", lat, err, rdat); end
    access(1, 1'b0, 32'h08, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rdat !== 32'hFFFF) begin n_fail++; $display("FAIL stale_oe got lat %0d err %b rdat %h exp 3 0 ffff", lat, err, rdat); end
  endtask

  task automatic test_reset_mid();
    int lat, we_cnt;
    int first = -1;
    int late_acks = 0;
    logic err;
    logic [31:0] rdat, we_adr, we_dat;
    drive(0, 1'b1, 1'b0, 32'h04, 32'h0);
    tick();
    n_checks++; if (busy !== 1'b1 || gpio_adr !== 32'h04) begin n_fail++; $display("FAIL mid_access got busy %b adr %h exp 1 04", busy, gpio_adr); end
    tick();
    sys_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err, gpio_we, busy} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_flags got %b exp 000000", {m0_ack, m0_err, m1_ack, m1_err, gpio_we, busy}); end
    n_checks++; if ((gpio_adr | gpio_dat_i | m0_rdat | m1_rdat) !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got adr %h dat %h r0 %h r1 %h exp 0", gpio_adr, gpio_dat_i, m0_rdat, m1_rdat); end
    sys_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m0_ack) late_acks++;
    end
    n_checks++; if (late_acks !== 0) begin n_fail++; $display("FAIL mid_no_ack got %0d exp 0", late_acks); end
    access(1, 1'b0, 32'h04, 32'h0, lat, err, rdat, we_cnt, we_adr, we_dat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rdat !== 32'h1234) begin n_fail++; $display("FAIL mid_m1_served got lat %0d err %b rdat %h exp 3 0 1234", lat, err, rdat); end
    drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (first < 0 && m0_ack) first = 3 * 10 + c;
      if (first < 0 && m1_ack) first = 4 * 10 + c;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (first !== 33) begin n_fail++; $display("FAIL mid_next_tie got code %0d exp 33 (m0 at cycle 3)", first); end
    for (int c = 0; c < 6; c++) tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_errors();
    test_no_stale();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
